// File: rtl/compare_8_if.sv
// Bundles the threshold-load and compare signals of compare_8.
// master drives the inputs and samples out; slave is the comparator side.
interface compare_8_if;
    logic       set;
    logic [7:0] cmp_static;
    logic [7:0] cmp;
    logic       out;

    modport master (
        output set,
        output cmp_static,
        output cmp,
        input  out
    );

    modport slave (
        input  set,
        input  cmp_static,
        input  cmp,
        output out
    );
endinterface

// File: rtl/compare_8.sv
// Registered 8-bit magnitude comparator: out <= (cmp < thr), where thr is loaded from cmp_static while set=1.
// Define COMPARE8_SYNC_EN to pass cmp through a 2-stage synchronizer first, which gives 3-cycle latency.
module compare_8 (
    input  logic        clk,
    input  logic        rst,
    compare_8_if.slave  bus
);

    logic [7:0] thr_q;
    logic [7:0] thr_d;
    logic       out_q;
    logic       out_d;
    logic [7:0] cmp_eff;

`ifdef COMPARE8_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync1_d;
    logic [7:0] sync2_q;
    logic [7:0] sync2_d;

    always_comb begin
        sync1_d = bus.cmp;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign cmp_eff = sync2_q;
`else
    assign cmp_eff = bus.cmp;
`endif

    // The compare uses the current thr, so a value loaded on this edge only takes effect on the next one.
    always_comb begin
        thr_d = thr_q;
        if (bus.set) begin
            thr_d = bus.cmp_static;
        end
        out_d = (cmp_eff < thr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q <= 8'h00;
            out_q <= 1'b0;
        end else begin
            thr_q <= thr_d;
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_compare_8.sv
// Directed self-checking bench for compare_8; it follows COMPARE8_SYNC_EN to select the expected latency.
module tb_compare_8;

`ifdef COMPARE8_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    compare_8_if bus_if ();

    compare_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_thr(input logic [7:0] v);
        bus_if.set        = 1'b1;
        bus_if.cmp_static = v;
        tick();
        bus_if.set        = 1'b0;
    endtask

    task automatic test_reset();
        rst               = 1'b1;
        bus_if.set        = 1'b1;
        bus_if.cmp_static = 8'hAA;
        bus_if.cmp        = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus_if.out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold cycle %0d: out=%b expected=0", i, bus_if.out);
            end
        end
        rst        = 1'b0;
        bus_if.set = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            vectors++;
            if (bus_if.out !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release cycle %0d: out=%b expected=0", i, bus_if.out);
            end
        end
    endtask

    task automatic test_reset_priority();
        bus_if.cmp = 8'h10;
        load_thr(8'h80);
        repeat (LAT + 1) tick();
        vectors++;
        if (bus_if.out !== 1'b1) begin
            miscompares++;
            $display("FAIL rstpri_pre: out=%b expected=1", bus_if.out);
        end
        rst               = 1'b1;
        bus_if.set        = 1'b1;
        bus_if.cmp_static = 8'hAA;
        tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpri_in_reset: out=%b expected=0", bus_if.out);
        end
        rst        = 1'b0;
        bus_if.set = 1'b0;
        repeat (LAT + 1) tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpri_thr_cleared: out=%b expected=0", bus_if.out);
        end
    endtask

    task automatic test_freeze_low();
        load_thr(8'h00);
        for (int i = 0; i < 1000; i++) begin
            bus_if.cmp        = i[0] ? 8'hEE : 8'hFF;
            bus_if.cmp_static = i[0] ? 8'h88 : 8'hAA;
            tick();
            vectors++;
            if (bus_if.out !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_low iter %0d: out=%b expected=0", i, bus_if.out);
            end
        end
    endtask

    // mode 0: thr=AA, 1: thr=01, 2: thr=FF, 3: thr=BB
    task automatic test_sweep(input int mode, input int steps);
        logic [7:0] thr;
        logic [7:0] c;
        logic       exp;
        case (mode)
            0:       thr = 8'hAA;
            1:       thr = 8'h01;
            2:       thr = 8'hFF;
            default: thr = 8'hBB;
        endcase
        load_thr(thr);
        for (int i = 0; i < steps; i++) begin
            c          = i[7:0];
            bus_if.cmp = c;
            repeat (LAT) tick();
            case (mode)
                0:       exp = (c <= 8'hA9);
                1:       exp = (c == 8'h00);
                2:       exp = (c != 8'hFF);
                default: exp = (c <= 8'hBA);
            endcase
            vectors++;
            if (bus_if.out !== exp) begin
                miscompares++;
                $display("FAIL sweep thr=%02h cmp=%02h: out=%b expected=%b", thr, c, bus_if.out, exp);
            end
        end
    endtask

    task automatic test_overlap();
        bus_if.cmp = 8'h50;
        load_thr(8'h40);
        repeat (LAT + 1) tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL overlap_pre: out=%b expected=0", bus_if.out);
        end
        bus_if.set        = 1'b1;
        bus_if.cmp_static = 8'h60;
        tick();
        bus_if.set = 1'b0;
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL overlap_load_edge: out=%b expected=0", bus_if.out);
        end
        tick();
        vectors++;
        if (bus_if.out !== 1'b1) begin
            miscompares++;
            $display("FAIL overlap_next_edge: out=%b expected=1", bus_if.out);
        end
    endtask

    task automatic test_back_to_back();
        bus_if.cmp = 8'h50;
        load_thr(8'h20);
        repeat (LAT + 1) tick();
        bus_if.set        = 1'b1;
        bus_if.cmp_static = 8'h60;
        tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_load60: out=%b expected=0", bus_if.out);
        end
        bus_if.cmp_static = 8'h30;
        tick();
        vectors++;
        if (bus_if.out !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_load30: out=%b expected=1", bus_if.out);
        end
        bus_if.cmp_static = 8'h70;
        tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_load70: out=%b expected=0", bus_if.out);
        end
        bus_if.set        = 1'b0;
        bus_if.cmp_static = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus_if.out !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_frozen cycle %0d: out=%b expected=1", i, bus_if.out);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] step_val [2];
        logic       after    [2];
        step_val[0] = 8'h10;
        after[0]    = 1'b1;
        step_val[1] = 8'hF0;
        after[1]    = 1'b0;
        bus_if.cmp = 8'h90;
        load_thr(8'h80);
        repeat (LAT + 1) tick();
        vectors++;
        if (bus_if.out !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_pre: out=%b expected=0", bus_if.out);
        end
        for (int s = 0; s < 2; s++) begin
            bus_if.cmp = step_val[s];
            for (int k = 1; k <= LAT + 1; k++) begin
                tick();
                vectors++;
                if (bus_if.out !== ((k >= LAT) ? after[s] : ~after[s])) begin
                    miscompares++;
                    $display("FAIL latency step %0d edge %0d: out=%b expected=%b",
                             s, k, bus_if.out, (k >= LAT) ? after[s] : ~after[s]);
                end
            end
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b1;
        bus_if.set        = 1'b0;
        bus_if.cmp_static = 8'h00;
        bus_if.cmp        = 8'h00;

        test_reset();
        test_freeze_low();
        test_sweep(0, 1000);
        test_sweep(1, 256);
        test_sweep(2, 256);
        test_sweep(3, 256);
        test_overlap();
        test_back_to_back();
        test_latency();
        test_reset_priority();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
